i2c_rx_parity_frame_checker: RTL and testbench

//  Serial receive-side frame checker for the I2C controller: deserialises DATA_WIDTH bits plus one parity bit,
//  MSB first, from a bit-strobe stream sampled in the FAST_CLOCK domain. Checks even or odd parity, then emits
//  a one-cycle DATA_VALID or PARITY_ERROR pulse. Also keeps a saturating error counter. Sits between the SDA

---
 rtl/i2c_rx_parity_frame_checker.sv | 104 ++++++++++
 tb/tb_i2c_rx_parity_frame_checker.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/i2c_rx_parity_frame_checker.sv
// Receive-side frame checker: shifts in DATA_WIDTH payload bits (MSB first) plus one parity bit,
// then pulses DATA_VALID or PARITY_ERROR and keeps a saturating parity-error count.
module i2c_rx_parity_frame_checker #(
  parameter int DATA_WIDTH    = 8,
  parameter int ERR_CNT_WIDTH = 8,
  parameter int CNT_WIDTH     = 4
) (
  input  logic                     FAST_CLOCK,
  input  logic                     RESET,
  input  logic                     FRAME_START,
  input  logic                     BIT_STROBE,
  input  logic                     BIT_IN,
  input  logic                     ODD_PARITY,
  input  logic                     ERR_CLEAR,
  output logic [DATA_WIDTH-1:0]    DATA_OUT,
  output logic                     DATA_VALID,
  output logic                     PARITY_ERROR,
  output logic                     BUSY,
  output logic [ERR_CNT_WIDTH-1:0] ERR_COUNT
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0]     LAST_BIT = CNT_WIDTH'(DATA_WIDTH - 1);
  localparam logic [ERR_CNT_WIDTH-1:0] ERR_MAX  = '1;

  state_t                state;
  logic [DATA_WIDTH-1:0] shreg;
  logic [CNT_WIDTH-1:0]  count;
  logic                  xor_acc;
  logic                  parity_done;
  logic                  parity_ok;
  logic                  err_event;

  // A start pulse on the parity strobe aborts the frame, so it never completes.
  assign parity_done = (state == PARITY) && BIT_STROBE && !FRAME_START;
  assign parity_ok   = (xor_acc ^ BIT_IN ^ ODD_PARITY) == 1'b0;
  assign err_event   = parity_done && !parity_ok;

  always_ff @(posedge FAST_CLOCK) begin
    if (RESET) begin
      state        <= IDLE;
      shreg        <= '0;
      count        <= '0;
      xor_acc      <= 1'b0;
      DATA_OUT     <= '0;
      DATA_VALID   <= 1'b0;
      PARITY_ERROR <= 1'b0;
      BUSY         <= 1'b0;
    end else begin
      DATA_VALID   <= 1'b0;
      PARITY_ERROR <= 1'b0;
      if (FRAME_START) begin
        state   <= DATA;
        BUSY    <= 1'b1;
        count   <= '0;
        xor_acc <= 1'b0;
        shreg   <= '0;
      end else begin
        case (state)
          DATA: begin
            if (BIT_STROBE) begin
              shreg   <= {shreg[DATA_WIDTH-2:0], BIT_IN};
              xor_acc <= xor_acc ^ BIT_IN;
              if (count == LAST_BIT) begin
                state <= PARITY;
                count <= '0;
              end else begin
                count <= count + 1'b1;
              end
            end
          end
          PARITY: begin
            if (parity_done) begin
              state        <= IDLE;
              BUSY         <= 1'b0;
              DATA_OUT     <= shreg;
              DATA_VALID   <= parity_ok;
              PARITY_ERROR <= !parity_ok;
            end
          end
          default: begin
            state <= IDLE;
            BUSY  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Clear beats a simultaneous error; the count sticks at all-ones.
  always_ff @(posedge FAST_CLOCK) begin
    if (RESET || ERR_CLEAR) begin
      ERR_COUNT <= '0;
    end else if (err_event && ERR_COUNT != ERR_MAX) begin
      ERR_COUNT <= ERR_COUNT + 1'b1;
    end
  end

endmodule

// File: tb/tb_i2c_rx_parity_frame_checker.sv
// Bench for i2c_rx_parity_frame_checker: four instances (widths 8/8/2/16, one with a 2-bit error
// counter) share one stimulus stream and are compared every cycle against a bit-queue frame model.
module tb_i2c_rx_parity_frame_checker;

  logic clk = 1'b0;
  logic rst, fs, bs, bin, odd, clr;
  always #5 clk = ~clk;

  localparam int WID [4] = '{8, 8, 2, 16};
  localparam int ECW [4] = '{8, 2, 8, 8};

  logic [7:0]  do0, do1, e0, e2, e3;
  logic [1:0]  do2, e1;
  logic [15:0] do3;
  logic [3:0]  dv, pe, busy;
  logic [15:0] dout [4];
  logic [7:0]  ecnt [4];

  assign dout[0] = {8'h00, do0};
  assign dout[1] = {8'h00, do1};
  assign dout[2] = {14'h0, do2};
  assign dout[3] = do3;
  assign ecnt[0] = e0;
  assign ecnt[1] = {6'h0, e1};
  assign ecnt[2] = e2;
  assign ecnt[3] = e3;

  i2c_rx_parity_frame_checker #(.DATA_WIDTH(8), .ERR_CNT_WIDTH(8), .CNT_WIDTH(4)) u_w8 (
    .FAST_CLOCK(clk), .RESET(rst), .FRAME_START(fs), .BIT_STROBE(bs), .BIT_IN(bin),
    .ODD_PARITY(odd), .ERR_CLEAR(clr), .DATA_OUT(do0), .DATA_VALID(dv[0]),
    .PARITY_ERROR(pe[0]), .BUSY(busy[0]), .ERR_COUNT(e0));
  i2c_rx_parity_frame_checker #(.DATA_WIDTH(8), .ERR_CNT_WIDTH(2), .CNT_WIDTH(4)) u_sat (
    .FAST_CLOCK(clk), .RESET(rst), .FRAME_START(fs), .BIT_STROBE(bs), .BIT_IN(bin),
    .ODD_PARITY(odd), .ERR_CLEAR(clr), .DATA_OUT(do1), .DATA_VALID(dv[1]),
    .PARITY_ERROR(pe[1]), .BUSY(busy[1]), .ERR_COUNT(e1));
  i2c_rx_parity_frame_checker #(.DATA_WIDTH(2), .ERR_CNT_WIDTH(8), .CNT_WIDTH(2)) u_w2 (
    .FAST_CLOCK(clk), .RESET(rst), .FRAME_START(fs), .BIT_STROBE(bs), .BIT_IN(bin),
    .ODD_PARITY(odd), .ERR_CLEAR(clr), .DATA_OUT(do2), .DATA_VALID(dv[2]),
    .PARITY_ERROR(pe[2]), .BUSY(busy[2]), .ERR_COUNT(e2));
  i2c_rx_parity_frame_checker #(.DATA_WIDTH(16), .ERR_CNT_WIDTH(8), .CNT_WIDTH(5)) u_w16 (
    .FAST_CLOCK(clk), .RESET(rst), .FRAME_START(fs), .BIT_STROBE(bs), .BIT_IN(bin),
    .ODD_PARITY(odd), .ERR_CLEAR(clr), .DATA_OUT(do3), .DATA_VALID(dv[3]),
    .PARITY_ERROR(pe[3]), .BUSY(busy[3]), .ERR_COUNT(e3));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Frame model: counts received bits and ones; the frame completes on bit WID+1.
  bit     m_act  [4];
  int     m_n    [4];
  int     m_ones [4];
  int     m_err  [4];
  longint m_acc  [4];
  longint m_data [4];
  bit     m_dv   [4];
  bit     m_pe   [4];

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      bit ev;
      bit ok;
      ev      = 1'b0;
      m_dv[k] = 1'b0;
      m_pe[k] = 1'b0;
      if (rst) begin
        m_act[k] = 1'b0; m_n[k] = 0; m_ones[k] = 0;
        m_acc[k] = 0; m_data[k] = 0; m_err[k] = 0;
      end else begin
        if (fs) begin
          m_act[k] = 1'b1; m_n[k] = 0; m_ones[k] = 0; m_acc[k] = 0;
        end else if (m_act[k] && bs) begin
          if (m_n[k] < WID[k]) begin
            m_acc[k]  = (m_acc[k] * 2 + longint'(bin)) % (longint'(1) << WID[k]);
            m_ones[k] = m_ones[k] + int'(bin);
            m_n[k]    = m_n[k] + 1;
          end else begin
            ok        = ((m_ones[k] + int'(bin) + int'(odd)) % 2) == 0;
            m_data[k] = m_acc[k];
            m_dv[k]   = ok;
            m_pe[k]   = !ok;
            ev        = !ok;
            m_act[k]  = 1'b0;
          end
        end
        if (clr) m_err[k] = 0;
        else if (ev && m_err[k] < (1 << ECW[k]) - 1) m_err[k] = m_err[k] + 1;
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("dv%0d", k),   64'(dv[k]),   64'(m_dv[k]));
      chk($sformatf("pe%0d", k),   64'(pe[k]),   64'(m_pe[k]));
      chk($sformatf("excl%0d", k), 64'(dv[k] & pe[k]), 64'd0);
      chk($sformatf("busy%0d", k), 64'(busy[k]), 64'(m_act[k]));
      chk($sformatf("data%0d", k), 64'(dout[k]), m_data[k]);
      chk($sformatf("err%0d", k),  64'(ecnt[k]), 64'(m_err[k]));
    end
  end

  task automatic cyc(input logic f, input logic s, input logic b, input logic c, input logic r);
    fs = f; bs = s; bin = b; clr = c; rst = r;
    @(negedge clk);
  endtask

  task automatic gap(input int maxgap);
    repeat ($urandom_range(0, maxgap)) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_frame(input logic [15:0] pl, input int w, input logic p, input int maxgap,
                            input logic clr_last, input logic abort_last);
    cyc(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    for (int i = w - 1; i >= 0; i--) begin
      gap(maxgap);
      cyc(1'b0, 1'b1, pl[i], 1'b0, 1'b0);
    end
    gap(maxgap);
    cyc(abort_last, 1'b1, p, clr_last, 1'b0);
  endtask

  task automatic send_bits(input int nbits);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (nbits) cyc(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
  endtask

  initial begin
    fs = 0; bs = 0; bin = 0; clr = 0; odd = 0; rst = 1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_data", 64'(dout[0]), 64'd0);
    chk("rst_busy", 64'(busy[0]), 64'd0);
    chk("rst_err",  64'(ecnt[0]), 64'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Even parity, 0xA5 has four ones, P=0 is correct
    odd = 0;
    send_frame(16'h00A5, 8, 1'b0, 2, 1'b0, 1'b0);
    chk("t1_dv",   64'(dv[0]),   64'd1);
    chk("t1_pe",   64'(pe[0]),   64'd0);
    chk("t1_data", 64'(dout[0]), 64'hA5);
    chk("t1_err",  64'(ecnt[0]), 64'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t1_dv_one_cycle", 64'(dv[0]), 64'd0);

    odd = 1;
    send_frame(16'h00A5, 8, 1'b0, 2, 1'b0, 1'b0);
    chk("t2_pe",   64'(pe[0]),   64'd1);
    chk("t2_dv",   64'(dv[0]),   64'd0);
    chk("t2_err",  64'(ecnt[0]), 64'd1);
    chk("t2_data", 64'(dout[0]), 64'hA5);
    send_frame(16'h00A5, 8, 1'b1, 2, 1'b0, 1'b0);
    chk("t2b_dv",  64'(dv[0]),   64'd1);

    odd = 0;
    send_bits(5);
    send_frame(16'h003C, 8, 1'b0, 2, 1'b0, 1'b0);
    chk("t3_dv",   64'(dv[0]),   64'd1);
    chk("t3_data", 64'(dout[0]), 64'h3C);

    send_bits(4);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t4_busy", 64'(busy[0]), 64'd0);
    chk("t4_dv",   64'(dv[0] | pe[0]), 64'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(16'h00FF, 8, 1'b0, 2, 1'b0, 1'b0);
    chk("t4_dv2",  64'(dv[0]),   64'd1);
    chk("t4_data", 64'(dout[0]), 64'hFF);

    // 2-bit error counter saturates at 3; clear on the error cycle wins
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      send_frame(16'h00A5, 8, 1'b1, 1, 1'b0, 1'b0);
      chk($sformatf("t5_sat%0d", i), 64'(e1), (i < 3) ? 64'(i + 1) : 64'd3);
    end
    send_frame(16'h00A5, 8, 1'b1, 1, 1'b1, 1'b0);
    chk("t5_clr", 64'(e1), 64'd0);
    chk("t5_pe",  64'(pe[1]), 64'd1);

    for (int f = 0; f < 300; f++) begin
      int sel;
      int r;
      int w;
      sel = $urandom_range(0, 2);
      w   = (sel == 0) ? 2 : (sel == 1) ? 8 : 16;
      r   = $urandom_range(0, 19);
      odd = 1'($urandom_range(0, 1));
      if (r == 0) send_bits($urandom_range(0, 12));
      if (r == 1) begin
        send_bits($urandom_range(0, 12));
        cyc(1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b1);
      end
      send_frame(16'($urandom), w, 1'($urandom_range(0, 1)), 7, r == 2, r == 3);
      if (r == 4) cyc(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      gap(3);
    end

    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
